input_conditioner: RTL and testbench

- Front-end stage for the pushbuttons and DIP switches on ui_in.
- Synchronises every raw input to clk, debounces each bit independently, and emits clean levels plus single-cycle press/release/change pulses.
- Sits directly upstream of the game state machine, which consumes only the conditioned outputs and never the raw pins.
- Guarantees switch state is read as the debounced value, never as a metastable or bouncing sample.

---
 rtl/input_conditioner.sv | 133 +++++++++++++
 tb/tb_input_conditioner.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Pushbutton / DIP-switch front end: 2-flop synchronise, per-bit debounce, level + pulse outputs.
// Optional auto-repeat on buttons is enabled by defining INPUT_CONDITIONER_AUTOREPEAT_EN.
module input_conditioner #(
   parameter int N_BTN           = 4,
   parameter int N_DSW           = 4,
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int CNT_W           = 15,
   parameter int REPEAT_DELAY    = 10_000_000,
   parameter int REPEAT_PERIOD   = 2_000_000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btns_raw,
   input  logic [N_DSW-1:0] dsws_raw,
   output logic [N_BTN-1:0] btns_level,
   output logic [N_BTN-1:0] btns_press,
   output logic [N_BTN-1:0] btns_release,
   output logic [N_DSW-1:0] dsws_level,
   output logic             dsws_change
);

   localparam int N = N_BTN + N_DSW;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 || (2 ** CNT_W) <= DEBOUNCE_CYCLES ||
       REPEAT_DELAY < 2 || REPEAT_PERIOD < 1) begin : g_bad_cfg
      $error("input_conditioner: invalid parameter set");
   end

   logic [N-1:0]     w_raw;
   logic [N-1:0]     r_meta;
   logic [N-1:0]     r_sync;
   logic [N-1:0]     r_stable;
   logic [N-1:0]     w_update;
   logic [N-1:0]     w_rise;
   logic [N-1:0]     w_fall;
   logic [N_BTN-1:0] w_rep;
   logic [N_BTN-1:0] r_btn_press;
   logic [N_BTN-1:0] r_btn_release;
   logic             r_dsw_change;

   // Buttons occupy the low bits of the combined vector, switches the high bits.
   assign w_raw = {dsws_raw, btns_raw};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= w_raw;
         r_sync <= r_meta;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_deb
         logic [CNT_W-1:0] r_cnt;

         assign w_update[gi] = (r_sync[gi] != r_stable[gi]) && (r_cnt == CNT_LAST);

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_cnt <= '0;
            end else if (r_sync[gi] == r_stable[gi] || r_cnt == CNT_LAST) begin
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   endgenerate

   assign w_rise = w_update & r_sync;
   assign w_fall = w_update & ~r_sync;

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
   localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   generate
      for (gi = 0; gi < N_BTN; gi++) begin : g_rep
         logic [TMR_W-1:0] r_tmr;
         logic             r_phase;
         logic [TMR_W-1:0] w_inc;

         // r_phase: 0 = waiting out the initial delay, 1 = periodic repeat.
         assign w_inc = r_tmr + TMR_W'(1);
         assign w_rep[gi] = r_stable[gi] && !w_update[gi] &&
                            (r_phase ? (w_inc == TMR_W'(REPEAT_PERIOD))
                                     : (w_inc == TMR_W'(REPEAT_DELAY - 1)));

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_tmr   <= '0;
               r_phase <= 1'b0;
            end else if (!r_stable[gi] || w_update[gi]) begin
               r_tmr   <= '0;
               r_phase <= 1'b0;
            end else if (w_rep[gi]) begin
               r_tmr   <= '0;
               r_phase <= 1'b1;
            end else begin
               r_tmr   <= w_inc;
            end
         end
      end
   endgenerate
`else
   assign w_rep = '0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stable      <= '0;
         r_btn_press   <= '0;
         r_btn_release <= '0;
         r_dsw_change  <= 1'b0;
      end else begin
         r_stable      <= r_stable ^ w_update;
         r_btn_press   <= w_rise[N_BTN-1:0] | w_rep;
         r_btn_release <= w_fall[N_BTN-1:0];
         r_dsw_change  <= |w_update[N-1:N_BTN];
      end
   end

   assign btns_level   = r_stable[N_BTN-1:0];
   assign dsws_level   = r_stable[N-1:N_BTN];
   assign btns_press   = r_btn_press;
   assign btns_release = r_btn_release;
   assign dsws_change  = r_dsw_change;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with short debounce/repeat constants.
// Auto-repeat expectations follow INPUT_CONDITIONER_AUTOREPEAT_EN.
module tb_input_conditioner;
   localparam int NB = 4;
   localparam int ND = 4;
   localparam int DC = 4;
   localparam int RD = 20;
   localparam int RP = 8;
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [NB-1:0] btns_raw = '0;
   logic [ND-1:0] dsws_raw = '0;
   logic [NB-1:0] btns_level, btns_press, btns_release;
   logic [ND-1:0] dsws_level;
   logic          dsws_change;

   int checks = 0;
   int failures = 0;

   input_conditioner #(
      .N_BTN(NB), .N_DSW(ND), .DEBOUNCE_CYCLES(DC), .CNT_W(3),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk), .reset(reset), .btns_raw(btns_raw), .dsws_raw(dsws_raw),
      .btns_level(btns_level), .btns_press(btns_press), .btns_release(btns_release),
      .dsws_level(dsws_level), .dsws_change(dsws_change)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({btns_level, btns_press, btns_release, dsws_level, dsws_change});
   endfunction

   initial begin
      logic [NB-1:0] exp_b;
      logic [ND-1:0] exp_d;
      int o;

      // Reset held while inputs toggle.
      for (int t = 0; t < 6; t++) begin
         btns_raw = 4'(t * 5 + 3);
         dsws_raw = 4'(t * 3 + 9);
         tick();
         check("rst_hold", all_outs(), 32'd0);
      end
      btns_raw = '0;
      dsws_raw = '0;
      tick();
      tick();
      reset = 1'b0;
      for (int t = 0; t < 10; t++) begin
         tick();
         check("post_rst", all_outs(), 32'd0);
      end
      $display("txn: reset hold/release checked=%0d", checks);

      // Clean press on btn0.
      btns_raw = 4'b0001;
      for (int t = 1; t <= 8; t++) begin
         tick();
         check("b0_level", btns_level, (t >= 6) ? 32'h1 : 32'h0);
         check("b0_press", btns_press, (t == 6) ? 32'h1 : 32'h0);
         check("b0_rel", btns_release, 32'h0);
      end
      $display("txn: btn0 press checked=%0d", checks);

      // Bounce on btn1: 1,0,1,0,1 then held.
      for (int t = 1; t <= 14; t++) begin
         if (t <= 5) btns_raw[1] = t[0];
         tick();
         exp_b = (t >= 10) ? 4'b0011 : 4'b0001;
         check("b1_level", btns_level, 32'(exp_b));
         check("b1_press", btns_press, (t == 10) ? 32'h2 : 32'h0);
      end
      $display("txn: btn1 bounce checked=%0d", checks);

      // 3-cycle glitch on dsw2.
      for (int t = 1; t <= 12; t++) begin
         dsws_raw = (t <= 3) ? 4'b0100 : 4'b0000;
         tick();
         check("d2_glitch_lvl", dsws_level, 32'h0);
         check("d2_glitch_chg", dsws_change, 32'h0);
      end
      $display("txn: dsw2 glitch checked=%0d", checks);

      // Multi-bit switch change on one edge.
      dsws_raw = 4'b1011;
      for (int t = 1; t <= 8; t++) begin
         tick();
         check("d_multi_lvl", dsws_level, (t >= 6) ? 32'hB : 32'h0);
         check("d_multi_chg", dsws_change, (t == 6) ? 32'h1 : 32'h0);
      end
      $display("txn: dsw multi-bit checked=%0d", checks);

      // Reset mid-debounce of btn3 (counter at 2), then full re-debounce of everything.
      btns_raw = 4'b1011;
      for (int t = 0; t < 4; t++) tick();
      reset = 1'b1;
      #1;
      check("rst_mid", all_outs(), 32'd0);
      tick();
      tick();
      reset = 1'b0;
      for (int t = 1; t <= 8; t++) begin
         tick();
         exp_b = (t >= 6) ? 4'b1011 : 4'b0000;
         exp_d = (t >= 6) ? 4'b1011 : 4'b0000;
         check("rst_b_lvl", btns_level, 32'(exp_b));
         check("rst_b_press", btns_press, (t == 6) ? 32'hB : 32'h0);
         check("rst_d_lvl", dsws_level, 32'(exp_d));
         check("rst_d_chg", dsws_change, (t == 6) ? 32'h1 : 32'h0);
      end
      $display("txn: reset mid-debounce checked=%0d", checks);

      // Release all buttons together.
      btns_raw = 4'b0000;
      for (int t = 1; t <= 8; t++) begin
         tick();
         check("rel_lvl", btns_level, (t >= 6) ? 32'h0 : 32'hB);
         check("rel_pulse", btns_release, (t == 6) ? 32'hB : 32'h0);
         check("rel_press", btns_press, 32'h0);
      end
      $display("txn: release checked=%0d", checks);

      // Long hold on btn2: auto-repeat pulses when enabled, then release.
      for (int t = 1; t <= 90; t++) begin
         btns_raw = (t <= 70) ? 4'b0100 : 4'b0000;
         tick();
         o = t - 6;
         exp_b = ((o == 0) ||
                  (AR && o >= RD - 1 && ((o - (RD - 1)) % RP) == 0 && t < 76)) ? 4'b0100 : 4'b0000;
         check("hold_press", btns_press, 32'(exp_b));
         check("hold_lvl", btns_level, (t >= 6 && t < 76) ? 32'h4 : 32'h0);
         check("hold_rel", btns_release, (t == 76) ? 32'h4 : 32'h0);
      end
      $display("txn: btn2 hold autorepeat=%0d checked=%0d", AR, checks);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
